// File: rtl/seg7_number_display.sv
// rtl/seg7_number_display.sv - binary to decimal/hex active-low 7-segment display driver
module seg7_number_display #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 3,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value,
  input  logic                  mode,
  output logic [DIGITS*7-1:0]   seg,
  output logic                  busy,
  output logic                  valid,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int HW = (WIDTH > BW) ? WIDTH : BW;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Out-of-range parameters stop elaboration.
  if (WIDTH < 1 || WIDTH > 26) begin : g_bad_width
    $error("seg7_number_display: WIDTH must be in 1..26");
  end
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg7_number_display: DIGITS must be in 1..8");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    snap_q, snap_d;
  logic                mode_q, mode_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic                sticky_q, sticky_d;
  logic [DIGITS*7-1:0] seg_q, seg_d;
  logic                overflow_q, overflow_d;
  logic                valid_q, valid_d;

  logic [BW-1:0]       bcd_adj;
  logic [HW-1:0]       hex_ext;
  logic                hex_ov;
  logic                disp_ov;
  logic [DIGITS*7-1:0] disp_seg;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'h0:    c = 7'b1000000;
      4'h1:    c = 7'b1111001;
      4'h2:    c = 7'b0100100;
      4'h3:    c = 7'b0110000;
      4'h4:    c = 7'b0011001;
      4'h5:    c = 7'b0010010;
      4'h6:    c = 7'b0000010;
      4'h7:    c = 7'b1111000;
      4'h8:    c = 7'b0000000;
      4'h9:    c = 7'b0010000;
      4'hA:    c = 7'b0001000;
      4'hB:    c = 7'b0000011;
      4'hC:    c = 7'b1000110;
      4'hD:    c = 7'b0100001;
      4'hE:    c = 7'b0000110;
      default: c = 7'b0001110;
    endcase
    return c;
  endfunction

  // Add-3 correction of every BCD nibble that would reach 10 or more after the shift.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Hex view of the snapshot, zero-extended, plus detection of bits beyond the last digit.
  always_comb begin
    hex_ext = HW'(snap_q);
    hex_ov  = 1'b0;
    for (int i = BW; i < HW; i++) begin
      hex_ov = hex_ov | hex_ext[i];
    end
  end

  // Digit selection, overflow dashes and leading-zero blanking for the finished result.
  always_comb begin
    logic       lead_zero;
    logic [3:0] dig;
    disp_seg  = '1;
    disp_ov   = mode_q ? hex_ov : sticky_q;
    lead_zero = 1'b1;
    dig       = 4'h0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig = mode_q ? hex_ext[4*i +: 4] : bcd_q[4*i +: 4];
      if (disp_ov) begin
        disp_seg[7*i +: 7] = SEG_DASH;
      end else if (BLANK_ZEROS && lead_zero && (i > 0) && (dig == 4'h0)) begin
        disp_seg[7*i +: 7] = SEG_BLANK;
      end else begin
        disp_seg[7*i +: 7] = seg_code(dig);
      end
      lead_zero = lead_zero & (dig == 4'h0);
    end
  end

  // Next-state and datapath updates for capture, shifting and the atomic output update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    mode_d     = mode_q;
    bcd_d      = bcd_q;
    sticky_d   = sticky_q;
    seg_d      = seg_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE: begin
        snap_d   = value;
        mode_d   = mode;
        bcd_d    = '0;
        sticky_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_SHIFT;
      end
      S_SHIFT: begin
        if (!mode_q) begin
          bcd_d  = {bcd_adj[BW-2:0], snap_q[WIDTH-1]};
          snap_d = snap_q << 1;
          if (bcd_adj[BW-1]) begin
            sticky_d = 1'b1;
          end
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        seg_d      = disp_seg;
        overflow_d = disp_ov;
        valid_d    = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any conversion in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      snap_q     <= '0;
      mode_q     <= 1'b0;
      bcd_q      <= '0;
      sticky_q   <= 1'b0;
      seg_q      <= '1;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      mode_q     <= mode_d;
      bcd_q      <= bcd_d;
      sticky_q   <= sticky_d;
      seg_q      <= seg_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign seg      = seg_q;
  assign overflow = overflow_q;
  assign valid    = valid_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg7_number_display.sv
// tb/tb_seg7_number_display.sv - directed self-checking bench for seg7_number_display
module tb_seg7_number_display;

  localparam logic [6:0] C0   = 7'b1000000;
  localparam logic [6:0] C1   = 7'b1111001;
  localparam logic [6:0] C2   = 7'b0100100;
  localparam logic [6:0] C3   = 7'b0110000;
  localparam logic [6:0] C5   = 7'b0010010;
  localparam logic [6:0] C7   = 7'b1111000;
  localparam logic [6:0] C9   = 7'b0010000;
  localparam logic [6:0] CA   = 7'b0001000;
  localparam logic [6:0] CF   = 7'b0001110;
  localparam logic [6:0] BL   = 7'b1111111;
  localparam logic [6:0] DASH = 7'b0111111;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic [7:0]  v0, v1, v2, v3;
  logic        m0, m1, m2, m3;
  logic [20:0] s0, s1;
  logic [13:0] s2;
  logic [6:0]  s3;
  logic        b0, b1, b2, b3;
  logic        vl0, vl1, vl2, vl3;
  logic        o0, o1, o2, o3;

  int tests = 0;
  int fails = 0;
  int busy_hi;

  always #5 clock = ~clock;

  seg7_number_display #(.WIDTH(8), .DIGITS(3), .BLANK_ZEROS(1'b1)) u0 (
    .clock(clock), .reset(reset), .value(v0), .mode(m0),
    .seg(s0), .busy(b0), .valid(vl0), .overflow(o0));

  seg7_number_display #(.WIDTH(8), .DIGITS(3), .BLANK_ZEROS(1'b0)) u1 (
    .clock(clock), .reset(reset), .value(v1), .mode(m1),
    .seg(s1), .busy(b1), .valid(vl1), .overflow(o1));

  seg7_number_display #(.WIDTH(8), .DIGITS(2), .BLANK_ZEROS(1'b1)) u2 (
    .clock(clock), .reset(reset), .value(v2), .mode(m2),
    .seg(s2), .busy(b2), .valid(vl2), .overflow(o2));

  seg7_number_display #(.WIDTH(8), .DIGITS(1), .BLANK_ZEROS(1'b1)) u3 (
    .clock(clock), .reset(reset), .value(v3), .mode(m3),
    .seg(s3), .busy(b3), .valid(vl3), .overflow(o3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    v0 = 8'd123; m0 = 1'b0;
    v1 = 8'd7;   m1 = 1'b0;
    v2 = 8'd100; m2 = 1'b0;
    v3 = 8'h1F;  m3 = 1'b1;

    // Reset state
    #12;
    chk("rst_seg", 32'(s0), 32'h1FFFFF);
    chk("rst_busy", 32'(b0), 32'd0);
    chk("rst_valid", 32'(vl0), 32'd0);
    chk("rst_ovf", 32'(o0), 32'd0);

    @(negedge clock);
    reset = 1'b0;

    // First period: capture on edge 1, result on edge 10
    busy_hi = 0;
    for (int e = 1; e <= 10; e++) begin
      tick(1);
      busy_hi += int'(b0);
      if (e == 9) begin
        chk("e9_seg_blank", 32'(s0), 32'h1FFFFF);
        chk("e9_valid_low", 32'(vl0), 32'd0);
      end
    end
    chk("busy_9_of_10", 32'(busy_hi), 32'd9);
    chk("dec123_seg", 32'(s0), 32'({C1, C2, C3}));
    chk("dec123_ovf", 32'(o0), 32'd0);
    chk("dec123_valid", 32'(vl0), 32'd1);
    chk("noblank7_seg", 32'(s1), 32'({C0, C0, C7}));
    chk("d2_100_seg", 32'(s2), 32'({DASH, DASH}));
    chk("d2_100_ovf", 32'(o2), 32'd1);
    chk("d1_hex1F_seg", 32'(s3), 32'(DASH));
    chk("d1_hex1F_ovf", 32'(o3), 32'd1);

    // Second period
    v0 = 8'd7; v1 = 8'd0; v2 = 8'd99; v3 = 8'h05;
    tick(10);
    chk("blank7_seg", 32'(s0), 32'({BL, BL, C7}));
    chk("noblank0_seg", 32'(s1), 32'({C0, C0, C0}));
    chk("d2_99_seg", 32'(s2), 32'({C9, C9}));
    chk("d2_99_ovf", 32'(o2), 32'd0);
    chk("d1_hex5_seg", 32'(s3), 32'(C5));
    chk("d1_hex5_ovf", 32'(o3), 32'd0);

    // Third period
    v0 = 8'd0; v1 = 8'd255; v2 = 8'hAF; m2 = 1'b1; v3 = 8'd9; m3 = 1'b0;
    tick(10);
    chk("blank0_seg", 32'(s0), 32'({BL, BL, C0}));
    chk("dec255_seg", 32'(s1), 32'({C2, C5, C5}));
    chk("d2_hexAF_seg", 32'(s2), 32'({CA, CF}));
    chk("d2_hexAF_ovf", 32'(o2), 32'd0);
    chk("d1_dec9_seg", 32'(s3), 32'(C9));

    // Fourth period: input changes mid-conversion are ignored
    v0 = 8'd255;
    tick(5);
    v0 = 8'd9;
    tick(5);
    chk("hold255_seg", 32'(s0), 32'({C2, C5, C5}));
    tick(10);
    chk("late9_seg", 32'(s0), 32'({BL, BL, C9}));

    // Hex with blank top digit
    v0 = 8'hAF; m0 = 1'b1;
    tick(10);
    chk("hexAF_seg", 32'(s0), 32'({BL, CA, CF}));
    chk("hexAF_ovf", 32'(o0), 32'd0);

    // Asynchronous reset in the middle of SHIFT
    v0 = 8'd123; m0 = 1'b0;
    tick(3);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_seg", 32'(s0), 32'h1FFFFF);
    chk("arst_busy", 32'(b0), 32'd0);
    chk("arst_valid", 32'(vl0), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    tick(9);
    chk("arst_e9_valid", 32'(vl0), 32'd0);
    tick(1);
    chk("arst_e10_seg", 32'(s0), 32'({C1, C2, C3}));
    chk("arst_e10_valid", 32'(vl0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_number_display.md
Name: seg7_number_display

Overview:
- Parametrised numeric display driver for the board's 7-segment digits.
- Converts an unsigned binary value to DIGITS decimal (BCD) or hex digits and drives one active-low 7-segment code per digit.
- Decimal conversion is sequential (shift-and-add-3), not combinational divide/modulo.
- Supports leading-zero blanking and overflow indication; sits in the top level between mother_board outputs and the HEXn pins.

Parameters:
- WIDTH, 8, bit width of the input value; legal range 1..26.
- DIGITS, 3, number of 7-segment digits driven; legal range 1..8.
- BLANK_ZEROS, 1, 1 = blank leading zero digits; digit 0 is never blanked.

Ports:
- clock  input  1  system clock (post-prescaler or raw); all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  WIDTH  unsigned number to display; sampled only at capture (see below).
- mode  input  1  0 = decimal, 1 = hexadecimal; sampled with value.
- seg  output  DIGITS*7  segment codes; digit i occupies seg[7*i+6:7*i]; bit order g..a (bit 6 = g, bit 0 = a); active-low.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  low from reset until the first result is registered, then high.
- overflow  output  1  registered with seg; high when value does not fit in DIGITS digits in the captured mode.

Behaviour:
- Reset (async, any state): state = IDLE, seg = all 1s (every digit blank), busy = 0, valid = 0, overflow = 0, shift counter = 0. Takes effect immediately, including mid-conversion; the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE. The block runs continuously, with no request/acknowledge handshake.
- IDLE, one cycle:
  - On the edge, snapshot value and mode, clear the BCD register and overflow sticky, set counter = 0, and go to SHIFT.
  - busy = 0 during IDLE.
- SHIFT, exactly WIDTH cycles:
  - Each edge, in decimal mode: add 3 to every BCD nibble >= 5, then shift {BCD, snapshot} left by 1.
  - A 1 shifted out of the top BCD nibble sets the overflow sticky.
  - In hex mode, the BCD register is unused; the snapshot is simply held. Cycle count is identical in both modes.
  - counter increments each edge; on counter = WIDTH-1, go to DONE.
- DONE, one cycle:
  - Register seg, overflow and valid = 1 together (atomic update), then go to IDLE.
  - busy = 1 throughout SHIFT and DONE.
- Update period is WIDTH+2 cycles. A value stable at capture edge k appears on seg at edge k+WIDTH+1.
- value/mode changes after capture are ignored until the next IDLE capture; outputs never show a mix of old and new digits.
- Hex digit i = snapshot[4i+3:4i], zero-extended above WIDTH.
- Hex overflow = 1 when WIDTH > 4*DIGITS and any snapshot bit at index >= 4*DIGITS is set.
- Decimal overflow = the sticky flag, equivalent to value >= 10^DIGITS.
- Overflow display: all digits show dash (g only, code 0111111); blanking does not apply.
- Leading-zero blanking (BLANK_ZEROS = 1, no overflow): a digit i > 0 is blank (1111111) if it and every digit above it are 0. Value 0 shows a single "0" in digit 0.
- Segment codes (g..a), active-low:
  - 0: 1000000
  - 1: 1111001
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - A: 0001000
  - b: 0000011
  - C: 1000110
  - d: 0100001
  - E: 0000110
  - F: 0001110
- Parameter values outside the legal ranges are rejected at elaboration.

Test Plan:
1. Reset, then default parameters with value = 123, mode = 0, held:
   - seg stays all 1s and valid = 0 until edge 9 after reset release.
   - Then digits 2/1/0 = 1111001 / 0100100 / 0110000, overflow = 0, valid = 1.
   - busy is high 9 of every 10 cycles.
2. value = 7, mode = 0, BLANK_ZEROS = 1 -> digit 0 = 1111000; digits 1 and 2 = 1111111.
   - With BLANK_ZEROS = 0, digits 1 and 2 = 1000000.
   - value = 0 -> digit 0 = 1000000, others blank.
3. value = 255, decimal -> digits 2/1/0 = 0100100 / 0010010 / 0010010.
   - Change value to 9 five cycles after capture -> seg still shows 255 at that conversion's DONE; 9 appears one period later.
4. DIGITS = 2, value = 100, decimal -> overflow = 1, both digits 0111111.
   - Then value = 99 -> overflow = 0, both digits 0010000.
5. Hex mode, value = 8'hAF, DIGITS = 3 -> digit 2 blank, digit 1 = 0001000, digit 0 = 0001110.
   - DIGITS = 1, value = 8'h1F, hex -> overflow = 1, dash.
6. Assert reset asynchronously (between edges) mid-SHIFT after a valid display:
   - seg all 1s, busy = 0, valid = 0 immediately.
   - After release, a fresh capture occurs on the first edge and the result arrives WIDTH+1 edges later.
